// File: rtl/usb_sc_tx_pkg.sv
// usb_sc_tx_pkg: shared cntl codes, PID and CRC16 constants, framer state encoding
package usb_sc_tx_pkg;
  localparam logic [7:0] TX_PACKET_START = 8'h02;
  localparam logic [7:0] TX_PACKET_DATA  = 8'h03;
  localparam logic [7:0] TX_PACKET_STOP  = 8'h04;
  localparam logic [3:0] DATA0 = 4'h3;
  localparam logic [3:0] DATA1 = 4'hB;
  localparam logic [15:0] CRC16_INIT      = 16'hFFFF;
  localparam logic [15:0] CRC16_POLY_REFL = 16'hA001;
  typedef enum logic [2:0] {
    IDLE, PID_OUT, DATA_WAIT, DATA_OUT, CRC_LO, CRC_HI, STOP_OUT
  } state_t;
endpackage

// File: rtl/sc_tx_packet_framer_if.sv
// sc_tx_packet_framer_if: send-stage byte port plus SIE-side framed byte port
interface sc_tx_packet_framer_if;
  logic       SCTxPortWEn;
  logic [7:0] SCTxPortData;
  logic [7:0] SCTxPortCntl;
  logic       SCTxPortRdy;
  logic [7:0] txByte;
  logic [7:0] txByteCntl;
  logic       txByteValid;
  logic       txByteAccept;
  logic       protocolErr;
  logic       overflowErr;
  modport slave (
    input  SCTxPortWEn, SCTxPortData, SCTxPortCntl, txByteAccept,
    output SCTxPortRdy, txByte, txByteCntl, txByteValid, protocolErr, overflowErr
  );
  modport master (
    output SCTxPortWEn, SCTxPortData, SCTxPortCntl, txByteAccept,
    input  SCTxPortRdy, txByte, txByteCntl, txByteValid, protocolErr, overflowErr
  );
endinterface

// File: rtl/usb_crc16_byte.sv
// usb_crc16_byte: combinational one-byte update of the reflected USB CRC16 (LSB first)
module usb_crc16_byte
  import usb_sc_tx_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [7:0]  data,
  output logic [15:0] crc_out
);
  always_comb begin
    crc_out = crc_in;
    for (int i = 0; i < 8; i++)
      crc_out = (crc_out[0] ^ data[i]) ? ((crc_out >> 1) ^ CRC16_POLY_REFL) : (crc_out >> 1);
  end
endmodule

// File: rtl/sc_tx_packet_framer.sv
// sc_tx_packet_framer: frames PID/data bytes into a SIE byte stream, appending CRC16 and stop byte
module sc_tx_packet_framer
  import usb_sc_tx_pkg::*;
#(
  parameter int MAX_DATA_BYTES = 64,
  parameter int CNT_W          = 7
) (
  input logic clk,
  input logic rst,
  sc_tx_packet_framer_if.slave bus
);
  state_t           r_state;
  logic [15:0]      r_crc;
  logic [15:0]      w_crc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_rdy, r_valid, r_perr, r_oerr;
  logic [7:0]       r_byte, r_cntl;
  logic             w_wr, w_acc;

  assign w_wr  = bus.SCTxPortWEn && r_rdy;
  assign w_acc = r_valid && bus.txByteAccept;
  assign bus.SCTxPortRdy = r_rdy;
  assign bus.txByte      = r_byte;
  assign bus.txByteCntl  = r_cntl;
  assign bus.txByteValid = r_valid;
  assign bus.protocolErr = r_perr;
  assign bus.overflowErr = r_oerr;

  usb_crc16_byte u_crc (.crc_in(r_crc), .data(bus.SCTxPortData), .crc_out(w_crc));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_crc   <= CRC16_INIT;
      r_cnt   <= '0;
      r_rdy   <= 1'b1;
      r_valid <= 1'b0;
      r_byte  <= 8'h00;
      r_cntl  <= 8'h00;
      r_perr  <= 1'b0;
      r_oerr  <= 1'b0;
    end else begin
      r_perr <= bus.SCTxPortWEn && !r_rdy;
      r_oerr <= 1'b0;
      case (r_state)
        IDLE: if (w_wr) begin
          if (bus.SCTxPortCntl == TX_PACKET_START) begin
            r_crc   <= CRC16_INIT;
            r_cnt   <= '0;
            r_byte  <= bus.SCTxPortData;
            r_cntl  <= TX_PACKET_START;
            r_valid <= 1'b1;
            r_rdy   <= 1'b0;
            r_state <= PID_OUT;
          end else r_perr <= 1'b1;
        end
        PID_OUT: if (w_acc) begin
          r_valid <= 1'b0;
          r_rdy   <= 1'b1;
          r_state <= (r_byte[3:0] == DATA0 || r_byte[3:0] == DATA1) ? DATA_WAIT : IDLE;
        end
        DATA_WAIT: if (w_wr) begin
          if (bus.SCTxPortCntl == TX_PACKET_DATA && r_cnt < CNT_W'(MAX_DATA_BYTES)) begin
            r_crc   <= w_crc;
            r_cnt   <= r_cnt + 1'b1;
            r_byte  <= bus.SCTxPortData;
            r_cntl  <= TX_PACKET_DATA;
            r_valid <= 1'b1;
            r_rdy   <= 1'b0;
            r_state <= DATA_OUT;
          end else if (bus.SCTxPortCntl == TX_PACKET_DATA) r_oerr <= 1'b1;
          else if (bus.SCTxPortCntl == TX_PACKET_STOP) begin
            r_byte  <= ~r_crc[7:0];
            r_cntl  <= TX_PACKET_DATA;
            r_valid <= 1'b1;
            r_rdy   <= 1'b0;
            r_state <= CRC_LO;
          end else r_perr <= 1'b1;
        end
        DATA_OUT: if (w_acc) begin
          r_valid <= 1'b0;
          r_rdy   <= 1'b1;
          r_state <= DATA_WAIT;
        end
        CRC_LO: if (w_acc) begin
          r_byte  <= ~r_crc[15:8];
          r_state <= CRC_HI;
        end
        CRC_HI: if (w_acc) begin
          r_byte  <= 8'h00;
          r_cntl  <= TX_PACKET_STOP;
          r_state <= STOP_OUT;
        end
        STOP_OUT: if (w_acc) begin
          r_valid <= 1'b0;
          r_rdy   <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sc_tx_packet_framer.sv
// tb_sc_tx_packet_framer: table-driven framing vectors plus stall, busy-write and mid-packet reset sequences
module tb_sc_tx_packet_framer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_fail = 0;

  sc_tx_packet_framer_if bus ();
  sc_tx_packet_framer #(.MAX_DATA_BYTES(64), .CNT_W(7)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] cntl, data;
    int         n;
    logic [7:0] ob[3];
    logic [7:0] oc[3];
    logic       perr, oerr;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(logic [7:0] c, d, int n, logic [7:0] b0, c0, b1, c1, b2, c2, logic pe, oe);
    vec_t v;
    v.cntl = c; v.data = d; v.n = n;
    v.ob[0] = b0; v.ob[1] = b1; v.ob[2] = b2;
    v.oc[0] = c0; v.oc[1] = c1; v.oc[2] = c2;
    v.perr = pe; v.oerr = oe;
    return v;
  endfunction

  function automatic logic [15:0] crc_upd(logic [15:0] c, logic [7:0] d);
    for (int i = 0; i < 8; i++) c = (c[0] ^ d[i]) ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    return c;
  endfunction

  task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic send(logic [7:0] c, d, logic pe, oe);
    int t = 0;
    @(negedge clk);
    while (!bus.SCTxPortRdy && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) chk("rdy timeout", bus.SCTxPortRdy, 1);
    bus.SCTxPortWEn = 1'b1; bus.SCTxPortCntl = c; bus.SCTxPortData = d;
    @(posedge clk); #1;
    bus.SCTxPortWEn = 1'b0;
    chk("protocolErr", bus.protocolErr, pe);
    chk("overflowErr", bus.overflowErr, oe);
  endtask

  task automatic expect_out(logic [7:0] b, c);
    int t = 0;
    @(negedge clk);
    while (!bus.txByteValid && t < 50) begin @(negedge clk); t++; end
    chk("txByteValid", bus.txByteValid, 1);
    chk("txByte", bus.txByte, b);
    chk("txByteCntl", bus.txByteCntl, c);
    @(posedge clk); #1;
  endtask

  task automatic quiet(int n);
    repeat (n) begin
      @(negedge clk);
      chk("idle valid", bus.txByteValid, 0);
      chk("idle rdy", bus.SCTxPortRdy, 1);
    end
  endtask

  initial begin
    logic [15:0] c;
    logic [7:0] d;
    bus.SCTxPortWEn = 1'b0; bus.SCTxPortData = 8'h00; bus.SCTxPortCntl = 8'h00;
    bus.txByteAccept = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst rdy", bus.SCTxPortRdy, 1);
    chk("rst valid", bus.txByteValid, 0);
    chk("rst txByte", bus.txByte, 8'h00);
    chk("rst txByteCntl", bus.txByteCntl, 8'h00);
    chk("rst perr", bus.protocolErr, 0);
    chk("rst oerr", bus.overflowErr, 0);
    rst = 1'b0;

    // handshake-only PID: one byte, then nothing more
    send(8'h02, 8'hD2, 0, 0);
    expect_out(8'hD2, 8'h02);
    quiet(3);

    tbl.push_back(mk(8'h03, 8'h55, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(8'h04, 8'h00, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(8'h02, 8'h4B, 1, 8'h4B, 8'h02, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(8'h04, 8'h00, 3, 8'h00, 8'h03, 8'h00, 8'h03, 8'h00, 8'h04, 0, 0));
    tbl.push_back(mk(8'h02, 8'hC3, 1, 8'hC3, 8'h02, 0, 0, 0, 0, 0, 0));
    for (int i = 1; i <= 9; i++) begin
      d = 8'h30 + 8'(i);
      tbl.push_back(mk(8'h03, d, 1, d, 8'h03, 0, 0, 0, 0, 0, 0));
      if (i == 3) tbl.push_back(mk(8'h02, 8'hAA, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    end
    tbl.push_back(mk(8'h04, 8'h00, 3, 8'hC8, 8'h03, 8'hB4, 8'h03, 8'h00, 8'h04, 0, 0));
    tbl.push_back(mk(8'h02, 8'h4B, 1, 8'h4B, 8'h02, 0, 0, 0, 0, 0, 0));
    c = 16'hFFFF;
    for (int i = 0; i < 66; i++) begin
      d = 8'(i * 7 + 1);
      if (i < 64) begin
        c = crc_upd(c, d);
        tbl.push_back(mk(8'h03, d, 1, d, 8'h03, 0, 0, 0, 0, 0, 0));
      end else tbl.push_back(mk(8'h03, d, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    end
    tbl.push_back(mk(8'h04, 8'h00, 3, ~c[7:0], 8'h03, ~c[15:8], 8'h03, 8'h00, 8'h04, 0, 0));

    foreach (tbl[v]) begin
      send(tbl[v].cntl, tbl[v].data, tbl[v].perr, tbl[v].oerr);
      for (int k = 0; k < tbl[v].n; k++) expect_out(tbl[v].ob[k], tbl[v].oc[k]);
    end
    quiet(2);

    // output stall mid-payload, with a stray write while busy
    send(8'h02, 8'hC3, 0, 0);
    expect_out(8'hC3, 8'h02);
    for (int i = 1; i <= 4; i++) begin
      send(8'h03, 8'h30 + 8'(i), 0, 0);
      expect_out(8'h30 + 8'(i), 8'h03);
    end
    bus.txByteAccept = 1'b0;
    send(8'h03, 8'h35, 0, 0);
    repeat (5) begin
      @(negedge clk);
      chk("stall valid", bus.txByteValid, 1);
      chk("stall txByte", bus.txByte, 8'h35);
      chk("stall rdy", bus.SCTxPortRdy, 0);
    end
    @(negedge clk);
    bus.SCTxPortWEn = 1'b1; bus.SCTxPortCntl = 8'h03; bus.SCTxPortData = 8'hEE;
    @(posedge clk); #1;
    bus.SCTxPortWEn = 1'b0;
    chk("busy write perr", bus.protocolErr, 1);
    chk("busy write txByte", bus.txByte, 8'h35);
    bus.txByteAccept = 1'b1;
    expect_out(8'h35, 8'h03);
    for (int i = 6; i <= 9; i++) begin
      send(8'h03, 8'h30 + 8'(i), 0, 0);
      expect_out(8'h30 + 8'(i), 8'h03);
    end
    send(8'h04, 8'h00, 0, 0);
    expect_out(8'hC8, 8'h03);
    expect_out(8'hB4, 8'h03);
    expect_out(8'h00, 8'h04);
    quiet(2);

    // reset while the CRC low byte is waiting
    send(8'h02, 8'hC3, 0, 0);
    expect_out(8'hC3, 8'h02);
    send(8'h03, 8'h31, 0, 0);
    expect_out(8'h31, 8'h03);
    bus.txByteAccept = 1'b0;
    send(8'h04, 8'h00, 0, 0);
    c = ~crc_upd(16'hFFFF, 8'h31);
    @(negedge clk);
    chk("crc_lo valid", bus.txByteValid, 1);
    chk("crc_lo byte", bus.txByte, c[7:0]);
    rst = 1'b1;
    #1;
    chk("async rst valid", bus.txByteValid, 0);
    chk("async rst rdy", bus.SCTxPortRdy, 1);
    @(negedge clk);
    rst = 1'b0;
    bus.txByteAccept = 1'b1;
    quiet(2);
    send(8'h02, 8'hD2, 0, 0);
    expect_out(8'hD2, 8'h02);
    quiet(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
